// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared fetch/decode defines: instruction width, the default NOP encoding
// (the same constant decode uses), the buffered fetch entry type and a word
// alignment helper.
// ----------------------------------------------------------------------------
package ifetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
// Two-entry in-order buffer of {addr, inst} between the instruction memory
// response and the decode stage. Flush empties the buffer and wins over any
// push/pop in the same cycle. Push and pop may coincide, including when full.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push_i, entry_i write an entry
//   pop_i           retire the head entry
//   flush_i         discard all entries
//   head_o          current head entry (undefined content when empty)
//   full_o, empty_o occupancy flags
//   count_o         number of valid entries (0..2)
// ----------------------------------------------------------------------------
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // At full, a push is only legal together with a pop; the write then
    // lands in the slot the head is leaving.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/ifetch.sv
// ----------------------------------------------------------------------------
// ifetch
// Instruction fetch stage. Issues word-aligned requests to instruction memory
// under a two-credit limit (buffered + in-flight), buffers in-order responses
// in a two-entry FIFO and presents them to decode. A redirect flushes the
// buffer and arranges for all in-flight responses to be dropped.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   jump_en_i, jump_addr_i         redirect request and target
//   imem_req_o, imem_addr_o        memory request / word-aligned address
//   imem_gnt_i                     request accepted (with imem_req_o)
//   imem_rvalid_i, imem_rdata_i    in-order response
//   inst_valid_o, inst_o,
//   inst_addr_o                    fetched instruction to decode
//   inst_ready_i                   decode accepts the presented instruction
// ----------------------------------------------------------------------------
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    logic [31:0]  pc_q, pc_d;
    logic [1:0]   outstanding_q, outstanding_d;
    logic [1:0]   discard_q, discard_d;
    logic         started_q;

    // Addresses of accepted requests, matched to responses in order.
    logic [31:0]  pend_addr_q [2];
    logic         pend_wr_q;
    logic         pend_rd_q;

    logic [31:0]  target;
    logic         credit_ok;
    logic         accept;
    logic         drop;
    logic         fifo_push;
    logic         fifo_pop;
    fetch_entry_t fifo_entry;
    fetch_entry_t fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [1:0]   fifo_count;

    assign target    = word_align(jump_addr_i);
    assign credit_ok = !fifo_full &&
                       (({1'b0, fifo_count} + {1'b0, outstanding_q}) < 3'd2);

    // started_q keeps the request low for the first cycle after reset release.
    assign imem_req_o  = started_q && credit_ok;
    assign imem_addr_o = jump_en_i ? target : pc_q;
    assign accept      = imem_req_o && imem_gnt_i;

    // A response is dropped when it belongs to a superseded stream: either a
    // redirect happens this very cycle, or earlier redirects left it owed.
    assign drop       = imem_rvalid_i && (jump_en_i || (discard_q != 2'd0));
    assign fifo_push  = imem_rvalid_i && !drop;
    assign fifo_pop   = inst_valid_o && inst_ready_i && !jump_en_i;
    assign fifo_entry = '{addr: pend_addr_q[pend_rd_q], inst: imem_rdata_i};

    ifetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .entry_i (fifo_entry),
        .pop_i   (fifo_pop),
        .flush_i (jump_en_i),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign inst_valid_o = !fifo_empty;
    assign inst_o       = fifo_empty ? NOP_INST : fifo_head.inst;
    assign inst_addr_o  = fifo_empty ? 32'h0    : fifo_head.addr;

    always_comb begin
        pc_d = pc_q;
        if (jump_en_i) begin
            pc_d = accept ? (target + 32'd4) : target;
        end else if (accept) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Dropped responses stay in outstanding until they return, so the credit
    // limit keeps holding across redirects.
    assign outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, imem_rvalid_i};

    always_comb begin
        discard_d = discard_q;
        if (jump_en_i) begin
            // Everything in flight is stale; a response in this cycle is
            // already accounted for here.
            discard_d = outstanding_q - {1'b0, imem_rvalid_i};
        end else if (imem_rvalid_i && (discard_q != 2'd0)) begin
            discard_d = discard_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= word_align(RESET_PC);
            outstanding_q  <= 2'd0;
            discard_q      <= 2'd0;
            started_q      <= 1'b0;
            pend_addr_q[0] <= 32'h0;
            pend_addr_q[1] <= 32'h0;
            pend_wr_q      <= 1'b0;
            pend_rd_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            started_q     <= 1'b1;
            if (accept) begin
                pend_addr_q[pend_wr_q] <= imem_addr_o;
                pend_wr_q              <= ~pend_wr_q;
            end
            if (imem_rvalid_i) begin
                pend_rd_q <= ~pend_rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1'b1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ifetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_ready_i  (inst_ready_i)
    );

    // Memory: one-cycle response unless mem_stall holds it; data = ~addr.
    logic        mem_stall = 1'b0;
    logic [31:0] mq [$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= 32'h0;
        end else begin
            if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
            if (!mem_stall && mq.size() > 0) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= ~mq.pop_front();
            end else begin
                imem_rvalid_i <= 1'b0;
            end
        end
    end

    logic [31:0] acc_log [$];
    logic [31:0] pop_a [$];
    logic [31:0] pop_i [$];
    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req_o && imem_gnt_i) acc_log.push_back(imem_addr_o);
            if (inst_valid_o && inst_ready_i) begin
                pop_a.push_back(inst_addr_o);
                pop_i.push_back(inst_o);
            end
        end
    end

    // Leaves the caller at the falling edge where reset is released (cycle C0).
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0;
        imem_gnt_i = 1'b1; inst_ready_i = 1'b1; mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        acc_log.delete(); pop_a.delete(); pop_i.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", inst_valid_o); else passed++;
        total++; if (inst_o !== NOP) $display("FAIL rst_inst: got %h exp %h", inst_o, NOP); else passed++;
        total++; if (inst_addr_o !== 32'h0) $display("FAIL rst_addr: got %h exp 0", inst_addr_o); else passed++;
        total++; if (imem_req_o !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req_o); else passed++;
        do_reset();
        #1;
        total++; if (imem_req_o !== 1'b0) $display("FAIL rel_req_c0: got %b exp 0", imem_req_o); else passed++;
        @(negedge clk); #1;
        total++; if (imem_req_o !== 1'b1) $display("FAIL rel_req_c1: got %b exp 1", imem_req_o); else passed++;
        total++; if (imem_addr_o !== 32'h0) $display("FAIL rel_addr_c1: got %h exp 0", imem_addr_o); else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_a;
        do_reset();
        @(negedge clk); #1;   // C1
        total++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) $display("FAIL str_c1: got req %b addr %h exp 1 0", imem_req_o, imem_addr_o); else passed++;
        @(negedge clk); #1;   // C2
        total++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b1) $display("FAIL str_c2: got req %b addr %h exp 1 4", imem_req_o, imem_addr_o); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL str_c2_valid: got %b exp 0", inst_valid_o); else passed++;
        @(negedge clk); #1;   // C3
        total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0) $display("FAIL str_first: got valid %b addr %h exp 1 0", inst_valid_o, inst_addr_o); else passed++;
        total++; if (inst_o !== 32'hFFFF_FFFF) $display("FAIL str_first_inst: got %h exp ffffffff", inst_o); else passed++;
        total++; if (imem_req_o !== 1'b0) $display("FAIL str_credit: got %b exp 0", imem_req_o); else passed++;
        repeat (12) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_a = 32'(k * 4);
            total++; if (pop_a.size() <= k || pop_a[k] !== exp_a || pop_i[k] !== ~exp_a) $display("FAIL str_pop%0d: got %h/%h exp %h/%h", k, (pop_a.size() > k) ? pop_a[k] : 32'hx, (pop_i.size() > k) ? pop_i[k] : 32'hx, exp_a, ~exp_a); else passed++;
        end
        total++; if (acc_log.size() < 3 || acc_log[2] !== 32'h8) $display("FAIL str_acc2: got %h exp 8", (acc_log.size() > 2) ? acc_log[2] : 32'hx); else passed++;
    endtask

    task automatic test_stall();
        logic [31:0] exp_a;
        do_reset();
        @(negedge clk);       // C1
        @(negedge clk);       // C2
        inst_ready_i = 1'b0;
        @(negedge clk);       // C3
        for (int c = 4; c <= 6; c++) begin
            @(negedge clk); #1;
            total++; if (imem_req_o !== 1'b0) $display("FAIL stall_req_c%0d: got %b exp 0", c, imem_req_o); else passed++;
            total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== 32'hFFFF_FFFF) $display("FAIL stall_hold_c%0d: got %b %h %h exp 1 0 ffffffff", c, inst_valid_o, inst_addr_o, inst_o); else passed++;
        end
        @(negedge clk);       // C7
        inst_ready_i = 1'b1;
        repeat (14) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_a = 32'(k * 4);
            total++; if (pop_a.size() <= k || pop_a[k] !== exp_a || pop_i[k] !== ~exp_a) $display("FAIL stall_pop%0d: got %h exp %h", k, (pop_a.size() > k) ? pop_a[k] : 32'hx, exp_a); else passed++;
        end
    endtask

    task automatic test_jump_outstanding();
        do_reset();
        mem_stall = 1'b1;
        @(negedge clk);       // C1 accept 0
        @(negedge clk);       // C2 accept 4
        @(negedge clk);       // C3 two in flight
        jump_en_i = 1'b1; jump_addr_i = 32'h100;
        #1;
        total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h100) $display("FAIL jo_c3: got req %b addr %h exp 0 100", imem_req_o, imem_addr_o); else passed++;
        @(negedge clk);       // C4
        jump_en_i = 1'b0; mem_stall = 1'b0;
        #1;
        total++; if (imem_req_o !== 1'b0) $display("FAIL jo_c4_req: got %b exp 0", imem_req_o); else passed++;
        @(negedge clk); #1;   // C5 stale response for 0
        total++; if (inst_valid_o !== 1'b0) $display("FAIL jo_c5_valid: got %b exp 0", inst_valid_o); else passed++;
        @(negedge clk); #1;   // C6
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) $display("FAIL jo_c6: got req %b addr %h exp 1 100", imem_req_o, imem_addr_o); else passed++;
        @(negedge clk); #1;   // C7
        total++; if (inst_valid_o !== 1'b0) $display("FAIL jo_c7_valid: got %b exp 0", inst_valid_o); else passed++;
        @(negedge clk); #1;   // C8
        total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h100 || inst_o !== ~32'h100) $display("FAIL jo_c8: got %b %h %h exp 1 100 %h", inst_valid_o, inst_addr_o, inst_o, ~32'h100); else passed++;
        repeat (6) @(negedge clk);
        total++; if (pop_a.size() < 2 || pop_a[0] !== 32'h100 || pop_a[1] !== 32'h104) $display("FAIL jo_seq: got %h %h exp 100 104", (pop_a.size() > 0) ? pop_a[0] : 32'hx, (pop_a.size() > 1) ? pop_a[1] : 32'hx); else passed++;
        total++; if (acc_log.size() < 4 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h100 || acc_log[3] !== 32'h104) $display("FAIL jo_acc: got %0d entries exp 0 4 100 104 prefix", acc_log.size()); else passed++;
    endtask

    task automatic test_jump_coincident();
        do_reset();
        @(negedge clk);       // C1 accept 0
        @(negedge clk);       // C2 response for 0 arrives, request granted
        jump_en_i = 1'b1; jump_addr_i = 32'h203;
        #1;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) $display("FAIL jc_c2: got req %b addr %h exp 1 200", imem_req_o, imem_addr_o); else passed++;
        @(negedge clk);       // C3
        jump_en_i = 1'b0;
        #1;
        total++; if (imem_addr_o !== 32'h204 || imem_req_o !== 1'b1) $display("FAIL jc_pc: got req %b addr %h exp 1 204", imem_req_o, imem_addr_o); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL jc_drop: got %b exp 0", inst_valid_o); else passed++;
        @(negedge clk); #1;   // C4
        total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h200 || inst_o !== ~32'h200) $display("FAIL jc_c4: got %b %h %h exp 1 200 %h", inst_valid_o, inst_addr_o, inst_o, ~32'h200); else passed++;
        repeat (4) @(negedge clk);
        total++; if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h200 || acc_log[2] !== 32'h204) $display("FAIL jc_acc: got %0d entries exp 0 200 204 prefix", acc_log.size()); else passed++;
        total++; if (pop_a.size() < 1 || pop_a[0] !== 32'h200) $display("FAIL jc_pop0: got %h exp 200", (pop_a.size() > 0) ? pop_a[0] : 32'hx); else passed++;
    endtask

    task automatic test_jump_stall();
        do_reset();
        inst_ready_i = 1'b0;
        repeat (4) @(negedge clk);   // C4: buffer full
        jump_en_i = 1'b1; jump_addr_i = 32'h40;
        #1;
        total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h40) $display("FAIL js_c4: got req %b addr %h exp 0 40", imem_req_o, imem_addr_o); else passed++;
        @(negedge clk);              // C5
        jump_en_i = 1'b0; inst_ready_i = 1'b1;
        #1;
        total++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) $display("FAIL js_flush: got %b %h exp 0 %h", inst_valid_o, inst_o, NOP); else passed++;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h40) $display("FAIL js_c5: got req %b addr %h exp 1 40", imem_req_o, imem_addr_o); else passed++;
        repeat (2) @(negedge clk); #1;   // C7
        total++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h40) $display("FAIL js_c7: got %b %h exp 1 40", inst_valid_o, inst_addr_o); else passed++;
        repeat (4) @(negedge clk);
        total++; if (pop_a.size() < 2 || pop_a[0] !== 32'h40 || pop_a[1] !== 32'h44) $display("FAIL js_seq: got %0d entries exp 40 44 prefix", pop_a.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_ready_i = 1'b0;
        repeat (3) @(negedge clk);   // C3: one buffered, one in flight
        #1;
        total++; if (inst_valid_o !== 1'b1) $display("FAIL rm_pre: got %b exp 1", inst_valid_o); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0 || imem_req_o !== 1'b0) $display("FAIL rm_async: got %b %h %h %b exp 0 %h 0 0", inst_valid_o, inst_o, inst_addr_o, imem_req_o, NOP); else passed++;
        do_reset();
        #1;
        total++; if (imem_req_o !== 1'b0) $display("FAIL rm_c0: got %b exp 0", imem_req_o); else passed++;
        @(negedge clk); #1;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) $display("FAIL rm_c1: got req %b addr %h exp 1 0", imem_req_o, imem_addr_o); else passed++;
        repeat (8) @(negedge clk);
        total++; if (pop_a.size() < 2 || pop_a[0] !== 32'h0 || pop_a[1] !== 32'h4 || pop_i[0] !== 32'hFFFF_FFFF) $display("FAIL rm_seq: got %0d entries exp 0 4 prefix", pop_a.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jump_outstanding();
        test_jump_coincident();
        test_jump_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
